// File: rtl/openhw_seqmul.sv
// openhw_seqmul: radix-2 iterative shift-and-add multiplier.
// Retires one multiplier bit per cycle through a single XLEN+1-bit adder,
// operating on operand magnitudes and applying the sign once at the end.
// Produces the full 2*XLEN-bit product for mul / mulh / mulhsu / mulhu.
module openhw_seqmul #(
    parameter int XLEN = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Start,
    input  logic                Flush,
    input  logic [XLEN-1:0]     X,
    input  logic [XLEN-1:0]     Y,
    input  logic                XSigned,
    input  logic                YSigned,
    output logic                Busy,
    output logic                Done,
    output logic [2*XLEN-1:0]   P
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Two's-complement negate of an operand-width value.
    function automatic logic [XLEN-1:0] negate_op(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negate of a product-width value.
    function automatic logic [2*XLEN-1:0] negate_prod(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    // FSM state and registered status outputs
    state_e state_q;
    state_e state_d;
    logic   busy_q;
    logic   busy_d;
    logic   done_q;
    logic   done_d;

    // Datapath registers. The accumulator's top bit (bit XLEN of A) is
    // always zero after each right shift, so only the low XLEN bits are
    // stored; the carry lives only inside the step adder.
    logic [XLEN-1:0]    a_q;
    logic [XLEN-1:0]    a_d;
    logic [XLEN-1:0]    q_q;
    logic [XLEN-1:0]    q_d;
    logic [XLEN-1:0]    xabs_q;
    logic [XLEN-1:0]    xabs_d;
    logic               neg_q;
    logic               neg_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [2*XLEN-1:0]  p_q;
    logic [2*XLEN-1:0]  p_d;

    // Combinational helpers
    logic               x_neg_s;
    logic               y_neg_s;
    logic [XLEN:0]      addend_s;
    logic [XLEN:0]      sum_s;
    logic [2*XLEN-1:0]  prod_mag_s;

    assign Busy = busy_q;
    assign Done = done_q;
    assign P    = p_q;

    // State register and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; Flush overrides everything, including Start
    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == LAST_STEP) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_FIX:  state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode from the next state so Busy/Done are registered
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
            ST_BUSY, ST_FIX: begin
                busy_d = 1'b1;
                done_d = 1'b0;
            end
            ST_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Operand sign detection and one shift-add step
    always_comb begin
        x_neg_s    = XSigned & X[XLEN-1];
        y_neg_s    = YSigned & Y[XLEN-1];
        if (q_q[0]) begin
            addend_s = {1'b0, xabs_q};
        end else begin
            addend_s = {(XLEN+1){1'b0}};
        end
        sum_s      = {1'b0, a_q} + addend_s;
        prod_mag_s = {a_q, q_q};
    end

    // Datapath next-state: capture magnitudes, iterate, then apply sign
    always_comb begin
        a_d    = a_q;
        q_d    = q_q;
        xabs_d = xabs_q;
        neg_d  = neg_q;
        cnt_d  = cnt_q;
        p_d    = p_q;
        if (Flush) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        // The most negative value negates to itself, which
                        // reads correctly as 2^(XLEN-1) when unsigned.
                        if (x_neg_s) begin
                            xabs_d = negate_op(X);
                        end else begin
                            xabs_d = X;
                        end
                        if (y_neg_s) begin
                            q_d = negate_op(Y);
                        end else begin
                            q_d = Y;
                        end
                        neg_d = x_neg_s ^ y_neg_s;
                        a_d   = {XLEN{1'b0}};
                        cnt_d = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_BUSY: begin
                    // {A, Q} = {Sum, Q} >> 1
                    a_d   = sum_s[XLEN:1];
                    q_d   = {sum_s[0], q_q[XLEN-1:1]};
                    cnt_d = cnt_q + CNT_ONE;
                end
                ST_FIX: begin
                    if (neg_q) begin
                        p_d = negate_prod(prod_mag_s);
                    end else begin
                        p_d = prod_mag_s;
                    end
                end
                ST_DONE: begin
                    p_d = p_q;
                end
                default: begin
                    p_d = p_q;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= {XLEN{1'b0}};
            q_q    <= {XLEN{1'b0}};
            xabs_q <= {XLEN{1'b0}};
            neg_q  <= 1'b0;
            cnt_q  <= {CNT_W{1'b0}};
            p_q    <= {(2*XLEN){1'b0}};
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            xabs_q <= xabs_d;
            neg_q  <= neg_d;
            cnt_q  <= cnt_d;
            p_q    <= p_d;
        end
    end

endmodule

// File: tb/tb_openhw_seqmul.sv
// Directed testbench for openhw_seqmul (XLEN=32) with an expected-product
// queue: products are pushed when Start is driven and popped on Done.
module tb_openhw_seqmul;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              Start;
    logic              Flush;
    logic [XLEN-1:0]   X;
    logic [XLEN-1:0]   Y;
    logic              XSigned;
    logic              YSigned;
    logic              Busy;
    logic              Done;
    logic [2*XLEN-1:0] P;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_p;

    openhw_seqmul #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Flush(Flush),
        .X(X), .Y(Y), .XSigned(XSigned), .YSigned(YSigned),
        .Busy(Busy), .Done(Done), .P(P)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: true product of the (sign-extended) operands, mod 2^64
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic xs, input logic ys);
        logic signed [65:0] ax;
        logic signed [65:0] ay;
        logic signed [65:0] pr;
        ax = xs ? {{34{x[31]}}, x} : {34'd0, x};
        ay = ys ? {{34{y[31]}}, y} : {34'd0, y};
        pr = ax * ay;
        return pr[63:0];
    endfunction

    // Drive one Start cycle; afterwards scramble operands to show they are captured
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic xs,
                            input logic ys, input logic push, input logic [63:0] exp);
        X = x; Y = y; XSigned = xs; YSigned = ys; Start = 1'b1;
        if (push) exp_q.push_back(exp);
        tick();
        Start = 1'b0;
        X = $urandom; Y = $urandom; XSigned = 1'($urandom); YSigned = 1'($urandom);
    endtask

    // Wait (bounded) for Done, check latency and product, then the return to IDLE.
    // If pulse_at > 0, Start is pulsed with other operands during that cycle.
    task automatic wait_done(input string tag, input int pulse_at);
        int n;
        logic [63:0] e;
        n = 1;
        chk({tag, "_busy_t1"}, 64'(Busy), 64'd1);
        while (Done !== 1'b1 && n < 60) begin
            if (n == pulse_at) begin
                X = 32'h1234_5678; Y = 32'h0000_0003; Start = 1'b1;
            end
            tick();
            Start = 1'b0;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(LAT));
        chk({tag, "_busy_done"}, 64'(Busy), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_P"}, P, e);
            last_p = e;
        end else begin
            chk({tag, "_queue_nonempty"}, 64'd0, 64'd1);
        end
        tick();
        chk({tag, "_done_pulse"}, 64'(Done), 64'd0);
        chk({tag, "_idle_busy"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] ry;
        logic        rxs;
        logic        rys;
        int          extra;
        reset = 1'b1; Start = 1'b0; Flush = 1'b0;
        X = '0; Y = '0; XSigned = 1'b0; YSigned = 1'b0;
        last_p = 64'd0;
        tick(); tick();
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_P", P, 64'd0);
        reset = 1'b0;
        tick();

        // Test-plan products
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFE_0000_0001);
        wait_done("umax", 0);
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done("sneg1", 0);
        start_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
        wait_done("smin2", 0);
        start_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFE_0000_0002);
        wait_done("su", 0);
        start_op(32'h0000_0000, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 64'd0);
        wait_done("zero", 0);

        // Start while busy is ignored; no second Done afterwards
        start_op(32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        wait_done("ign", 5);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1) extra++;
            tick();
        end
        chk("ign_no_2nd_done", 64'(extra), 64'd0);

        // Flush at t+10: IDLE at t+11, no Done, P held; restart at t+11
        start_op(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 1'b0, 64'd0);
        extra = 0;
        for (int i = 1; i < 10; i++) begin
            if (Done === 1'b1) extra++;
            tick();
        end
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("flush_busy", 64'(Busy), 64'd0);
        chk("flush_done", 64'(Done | (extra != 0)), 64'd0);
        chk("flush_P_held", P, last_p);
        start_op(32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 1'b0, 1'b1,
                 model(32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 1'b0));
        wait_done("post_flush", 0);

        // Start and Flush together in IDLE: stays IDLE
        Start = 1'b1; Flush = 1'b1;
        tick();
        Start = 1'b0; Flush = 1'b0;
        chk("sf_busy", 64'(Busy), 64'd0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1 || Busy === 1'b1) extra++;
            tick();
        end
        chk("sf_no_op", 64'(extra), 64'd0);
        chk("sf_P_held", P, last_p);

        // Reset at t+20 mid-operation
        start_op(32'h0F0F_0F0F, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 64'd0);
        for (int i = 1; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_busy", 64'(Busy), 64'd0);
        chk("mrst_done", 64'(Done), 64'd0);
        chk("mrst_P", P, 64'd0);
        last_p = 64'd0;

        // Pseudo-random operands and sign modes against the model
        for (int k = 0; k < 6; k++) begin
            rx = $urandom; ry = $urandom; rxs = 1'(k); rys = 1'(k >> 1);
            start_op(rx, ry, rxs, rys, 1'b1, model(rx, ry, rxs, rys));
            wait_done("rand", 0);
        end

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
